// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack pulse).
// Define SRAM_ARBITER_ROUND_ROBIN_EN for alternating tie-break; default gives port 0 fixed priority.
module sram_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_p0_req,
  input  logic        in_p1_req,
  input  logic [15:0] in_p0_address,
  input  logic [15:0] in_p1_address,
  input  logic [15:0] in_p0_wdata,
  input  logic [15:0] in_p1_wdata,
  input  logic        in_p0_write,
  input  logic        in_p1_write,
  output logic        out_p0_ack,
  output logic        out_p1_ack,
  output logic [15:0] out_rdata,
  output logic [15:0] out_sram_address,
  output logic [15:0] out_sram_data,
  output logic        out_sram_write_enable,
  output logic        out_sram_output_enable,
  input  logic [15:0] in_sram_data,
  output logic        out_grant
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]  state_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        write_q;
  logic        grant_q;
  logic [3:0]  cnt_q;
  logic        any_req;
  logic        winner;

  assign any_req = in_p0_req | in_p1_req;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  logic last_q;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    winner = ~in_p0_req;
    if (in_p0_req && in_p1_req) winner = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_q <= winner;
    end
  end
`else
  assign winner = ~in_p0_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      grant_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            addr_q  <= winner ? in_p1_address : in_p0_address;
            wdata_q <= winner ? in_p1_wdata   : in_p0_wdata;
            write_q <= winner ? in_p1_write   : in_p0_write;
            cnt_q   <= WAIT_LOAD;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (!write_q) rdata_q <= in_sram_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes and acks are also gated by reset_n so nothing fires during the reset cycle.
  logic in_access;
  logic in_done;

  assign in_access = reset_n && (state_q == ACCESS);
  assign in_done   = reset_n && (state_q == DONE);

  assign out_sram_address       = addr_q;
  assign out_sram_data          = wdata_q;
  assign out_sram_write_enable  = in_access && write_q;
  assign out_sram_output_enable = in_access && !write_q;
  assign out_p0_ack             = in_done && !grant_q;
  assign out_p1_ack             = in_done && grant_q;
  assign out_rdata              = rdata_q;
  assign out_grant              = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_STATES=1 instance for most vectors, WAIT_STATES=0 instance for latency.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p1_req, p0_write, p1_write;
  logic [15:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, sram_we, sram_oe, grant;
  logic [15:0] rdata, sram_addr, sram_wdata, sram_din;

  logic        z_req;
  logic [15:0] z_addr;
  logic        z_ack0, z_ack1, z_we, z_oe, z_grant;
  logic [15:0] z_rdata, z_sram_addr, z_sram_wdata, z_sram_din;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h3000: rom = 16'h9040;
      16'h3001: rom = 16'h5A5A;
      16'h3002: rom = 16'h7777;
      16'h3004: rom = 16'h0BFE;
      16'h3006: rom = 16'h0FF9;
      16'h0000: rom = 16'hFFFF;
      default:  rom = 16'hDEAD;
    endcase
  endfunction

  assign sram_din   = rom(sram_addr);
  assign z_sram_din = rom(z_sram_addr);

  sram_arbiter #(.WAIT_STATES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_p0_req(p0_req), .in_p1_req(p1_req),
    .in_p0_address(p0_addr), .in_p1_address(p1_addr),
    .in_p0_wdata(p0_wdata), .in_p1_wdata(p1_wdata),
    .in_p0_write(p0_write), .in_p1_write(p1_write),
    .out_p0_ack(p0_ack), .out_p1_ack(p1_ack),
    .out_rdata(rdata),
    .out_sram_address(sram_addr), .out_sram_data(sram_wdata),
    .out_sram_write_enable(sram_we), .out_sram_output_enable(sram_oe),
    .in_sram_data(sram_din),
    .out_grant(grant)
  );

  sram_arbiter #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .reset_n(reset_n),
    .in_p0_req(z_req), .in_p1_req(1'b0),
    .in_p0_address(z_addr), .in_p1_address(16'h0000),
    .in_p0_wdata(16'h0000), .in_p1_wdata(16'h0000),
    .in_p0_write(1'b0), .in_p1_write(1'b0),
    .out_p0_ack(z_ack0), .out_p1_ack(z_ack1),
    .out_rdata(z_rdata),
    .out_sram_address(z_sram_addr), .out_sram_data(z_sram_wdata),
    .out_sram_write_enable(z_we), .out_sram_output_enable(z_oe),
    .in_sram_data(z_sram_din),
    .out_grant(z_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE; returns one cycle after the ack, back in IDLE.
  task automatic run_txn(input logic port, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int exp_lat, input string tag);
    int lat = 0;
    int oe_n = 0;
    int we_n = 0;
    logic other = 1'b0;
    logic seen = 1'b0;
    logic [15:0] we_addr = '0;
    logic [15:0] we_data = '0;
    if (!port) begin
      p0_req = 1'b1; p0_addr = addr; p0_wdata = wd; p0_write = wr;
    end else begin
      p1_req = 1'b1; p1_addr = addr; p1_wdata = wd; p1_write = wr;
    end
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (sram_oe) oe_n++;
      if (sram_we) begin
        we_n++;
        we_addr = sram_addr;
        we_data = sram_wdata;
      end
      if (port ? p0_ack : p1_ack) other = 1'b1;
      if (port ? p1_ack : p0_ack) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_grant"}, {31'b0, grant}, {31'b0, port});
    check({tag, "_other_ack"}, {31'b0, other}, 0);
    if (wr) begin
      check({tag, "_we_cycles"}, we_n, exp_lat - 1);
      check({tag, "_oe_cycles"}, oe_n, 0);
      check({tag, "_we_addr"}, {16'b0, we_addr}, {16'b0, addr});
      check({tag, "_we_data"}, {16'b0, we_data}, {16'b0, wd});
    end else begin
      check({tag, "_oe_cycles"}, oe_n, exp_lat - 1);
      check({tag, "_we_cycles"}, we_n, 0);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, {30'b0, p0_ack, p1_ack}, 0);
  endtask

  initial begin
    int k;
    int exp_port;
    logic got_ack;
    reset_n = 1'b0;
    p0_req = 0; p1_req = 0; p0_write = 0; p1_write = 0;
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    z_req = 0; z_addr = 0;

    repeat (2) tick();
    check("rst_acks", {30'b0, p0_ack, p1_ack}, 0);
    check("rst_strobes", {30'b0, sram_we, sram_oe}, 0);
    check("rst_rdata", {16'b0, rdata}, 0);
    check("rst_grant", {31'b0, grant}, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_outs", {28'b0, p0_ack, p1_ack, sram_we, sram_oe}, 0);

    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 3, "p0_rd_3000");
    check("p0_rd_3000_data", {16'b0, rdata}, 32'h9040);

    run_txn(1'b1, 1'b0, 16'h3006, 16'h0000, 3, "p1_rd_3006");
    check("p1_rd_3006_data", {16'b0, rdata}, 32'h0FF9);
    run_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 3, "p1_rd_0000");
    check("p1_rd_0000_data", {16'b0, rdata}, 32'hFFFF);

    run_txn(1'b0, 1'b1, 16'h3002, 16'h1234, 3, "p0_wr_3002");
    check("wr_keeps_rdata", {16'b0, rdata}, 32'hFFFF);
    repeat (3) tick();
    check("idle_keeps_rdata", {16'b0, rdata}, 32'hFFFF);

    // Reset in the middle of an access
    p0_req = 1'b1; p0_addr = 16'h3000; p0_write = 1'b0;
    tick();
    check("abort_in_access", {31'b0, sram_oe}, 1);
    reset_n = 1'b0;
    #1;
    check("abort_oe_gated", {31'b0, sram_oe}, 0);
    tick();
    check("abort_idle_outs", {28'b0, p0_ack, p1_ack, sram_we, sram_oe}, 0);
    check("abort_rdata_clr", {16'b0, rdata}, 0);
    p0_req = 1'b0;
    reset_n = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p0_ack || p1_ack || sram_oe || sram_we) got_ack = 1'b1;
    end
    check("abort_no_ack", {31'b0, got_ack}, 0);
    run_txn(1'b1, 1'b0, 16'h3006, 16'h0000, 3, "reissue");
    check("reissue_data", {16'b0, rdata}, 32'h0FF9);

    // Both ports hold read requests; fresh reset makes the first tie go to port 0
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    p0_req = 1'b1; p0_addr = 16'h3000; p0_write = 1'b0;
    p1_req = 1'b1; p1_addr = 16'h3001; p1_write = 1'b0;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (!(p0_ack || p1_ack) && k < 20) begin
        tick();
        k++;
      end
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      exp_port = g % 2;
`else
      exp_port = 0;
`endif
      check($sformatf("arb%0d_ack", g), {30'b0, p1_ack, p0_ack}, (exp_port == 1) ? 32'd2 : 32'd1);
      check($sformatf("arb%0d_rdata", g), {16'b0, rdata}, (exp_port == 1) ? 32'h5A5A : 32'h9040);
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) tick();

    // Zero wait states
    z_req = 1'b1; z_addr = 16'h3004;
    k = 0;
    got_ack = 1'b0;
    exp_port = 0;
    while (!got_ack && k < 20) begin
      tick();
      k++;
      if (z_oe) exp_port++;
      if (z_ack0) got_ack = 1'b1;
    end
    check("ws0_lat", k, 2);
    check("ws0_oe_cycles", exp_port, 1);
    check("ws0_rdata", {16'b0, z_rdata}, 32'h0BFE);
    check("ws0_no_p1_ack", {31'b0, z_ack1}, 0);
    z_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra ACCESS cycles held before read-data capture (0..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  reset: synchronous, active-low.
REQ-004 SHALL have ports in_p0_req / in_p1_req  input  1  access request from port 0 (CPU) / port 1 (loader/debug).
REQ-005 SHALL have ports in_p0_address / in_p1_address  input  16  word address; held stable while req high.
REQ-006 SHALL have ports in_p0_wdata / in_p1_wdata  input  16  write data; held stable while req high.
REQ-007 SHALL have ports in_p0_write / in_p1_write  input  1  1 = write, 0 = read; held stable while req high.
REQ-008 SHALL have ports out_p0_ack / out_p1_ack  output  1  one-cycle completion pulse.
REQ-009 SHALL have port out_rdata  output  16  read data of the last completed read; shared by both ports.
REQ-010 SHALL have ports out_sram_address / out_sram_data  output  16  SRAM address / write-data drive.
REQ-011 SHALL have ports out_sram_write_enable / out_sram_output_enable  output  1  SRAM strobes.
REQ-012 SHALL have port in_sram_data  input  16  combinational SRAM read data.
REQ-013 SHALL have port out_grant  output  1  port owning the current or last transaction (0/1).

Function
REQ-014 SHALL implement states IDLE, ACCESS, DONE.
REQ-015 IDLE with any req SHALL pick a winner, latch its address/wdata/write into internal registers, load the wait counter with WAIT_STATES, and enter ACCESS.
REQ-016 IDLE with no req SHALL remain in IDLE.
REQ-017 ACCESS SHALL drive latched address/wdata, write_enable = latched write, output_enable = !latched write; both strobes SHALL be 0 in every other state.
REQ-018 ACCESS SHALL decrement the counter each cycle; at counter 0 it SHALL enter DONE, capturing in_sram_data into out_rdata on that edge for reads only.
REQ-019 DONE SHALL assert exactly one ack (the granted port) for one cycle, then return to IDLE.
REQ-020 Latency SHALL be: req sampled in IDLE at cycle N -> ack high in cycle N+2+WAIT_STATES.
REQ-021 out_rdata SHALL hold its value across writes and idle cycles.
REQ-022 Requester SHALL drop req on the edge ending the ack cycle; a req still high in the following IDLE SHALL be treated as a new transaction.
REQ-023 Input changes during ACCESS/DONE SHALL NOT affect the transaction in flight.
REQ-024 Simultaneous requests SHALL be resolved per REQ-031/REQ-032; the loser SHALL be served at the next IDLE if its req is still high.

Reset
REQ-025 With reset_n low at a rising edge, the next state SHALL be IDLE, in every state including ACCESS and DONE.
REQ-026 Reset SHALL clear out_rdata, all internal registers and the counter to 0; out_grant SHALL reset to 0.
REQ-027 Reset SHALL clear the last-winner bit to 1, so port 0 wins the first tie.
REQ-028 During reset and the first cycle after it, acks and SRAM strobes SHALL be 0.
REQ-029 Reset mid-ACCESS SHALL abort the access; no ack SHALL be issued for it.

Configuration
REQ-030 Macro SRAM_ARBITER_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-031 With SRAM_ARBITER_ROUND_ROBIN_EN defined, ties SHALL go to the port that did not win the previous grant.
REQ-032 Without SRAM_ARBITER_ROUND_ROBIN_EN, port 0 SHALL always win ties and the last-winner bit SHALL be absent.

Verification
REQ-033 Port-0 read, address 0x3000, WAIT_STATES=1 -> out_p0_ack high in cycle N+3, out_rdata=0x9040, out_sram_output_enable high 2 cycles.
REQ-034 Port-1 read, address 0x3006 then 0x0000 -> out_rdata 0x0FF9 then 0xFFFF, out_p1_ack each time, out_p0_ack never.
REQ-035 Port-0 write, address 0x3002, data 0x1234 -> out_sram_write_enable high 2 cycles with address 0x3002 and data 0x1234; out_rdata unchanged; ack.
REQ-036 Both ports request reads of 0x3000 and 0x3001 held continuously -> round-robin build: grants 0,1,0,1; fixed-priority build: port 1 starved while port 0 holds req.
REQ-037 reset_n low during ACCESS -> IDLE next cycle, strobes 0, no ack; reissued req completes normally.
REQ-038 WAIT_STATES=0 read of 0x3004 -> ack in cycle N+2, out_rdata=0x0BFE.
